// File: rtl/lf_pkg.sv
// Shared types for the line-following drive controller: FSM states,
// tape classification and H-bridge direction codes.
package lf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_LOST    = 3'd3,
        ST_HALT    = 3'd4
    } lf_state_e;

    typedef enum logic [2:0] {
        CL_NONE      = 3'd0,
        CL_CENTRE    = 3'd1,
        CL_LEFTSIDE  = 3'd2,
        CL_RIGHTSIDE = 3'd3,
        CL_MARK      = 3'd4
    } lf_class_e;

    // Direction codes are {L[1:0], R[1:0]}.
    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b1001;
    localparam logic [3:0] DIR_LEFT  = 4'b0101;
    localparam logic [3:0] DIR_RIGHT = 4'b1010;
    localparam logic [3:0] DIR_REV   = 4'b0110;

    function automatic logic [1:0] en_gate(input logic drive, input logic pwm);
        if (drive && pwm) begin
            return 2'b11;
        end else begin
            return 2'b00;
        end
    endfunction

endpackage

// File: rtl/line_follow_ctrl_sens_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input after DEB_CYCLES consecutive identical samples.
module sens_debounce #(
    parameter int   DEB_CYCLES = 16,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             acc_q;
    logic             acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Synchroniser, accepted value and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            acc_q  <= RST_VAL;
            cnt_q  <= CNT_W'(0);
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    // Any sample that agrees with the accepted value restarts the count.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (sync_q == acc_q) begin
            cnt_d = CNT_W'(0);
        end else if (cnt_q == CNT_LAST) begin
            acc_d = sync_q;
            cnt_d = CNT_W'(0);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign q_o = acc_q;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following drive controller: filtered sensors, drive-mode FSM and
// PWM-gated motor enables. Define LINE_SEARCH_EN to make LOST spin in place.
module line_follow_ctrl
    import lf_pkg::*;
#(
    parameter int NUM_SENS    = 3,
    parameter int DEB_CYCLES  = 16,
    parameter int PWM_W       = 8,
    parameter int BACKOFF_CYC = 50000,
    parameter int LOST_CYC    = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_SENS-1:0] induct_n,
    input  logic                proxim,
    input  logic [PWM_W-1:0]    duty,
    output logic [3:0]          motorIn,
    output logic [1:0]          motorEn,
    output logic [2:0]          state_o
);

    localparam int CTR     = NUM_SENS / 2;
    localparam int TMR_MAX = (BACKOFF_CYC > 2 * LOST_CYC) ? BACKOFF_CYC : 2 * LOST_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_SAT   = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0] LOST_LAST = TMR_W'(LOST_CYC - 1);
    localparam logic [TMR_W-1:0] BACK_LAST = TMR_W'(BACKOFF_CYC - 1);
`ifdef LINE_SEARCH_EN
    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(2 * LOST_CYC - 1);
`endif

    logic [NUM_SENS-1:0] induct_filt_s;
    logic                proxim_filt_s;
    lf_class_e           class_s;
    lf_state_e           state_q;
    lf_state_e           state_d;
    logic [TMR_W-1:0]    tmr_q;
    logic [TMR_W-1:0]    tmr_d;
    logic [PWM_W-1:0]    pwm_cnt_q;
    logic [PWM_W-1:0]    duty_q;
    logic [PWM_W-1:0]    duty_eff_s;
    logic                pwm_s;
    logic [3:0]          motor_in_q;
    logic [3:0]          motor_in_d;
    logic [1:0]          motor_en_q;
    logic [1:0]          motor_en_d;

    // Idle tape sensors read high, so those filters start at 1 (no tape)
    // rather than presenting a spurious MARK straight out of reset.
    for (genvar i = 0; i < NUM_SENS; i++) begin : g_induct
        sens_debounce #(
            .DEB_CYCLES(DEB_CYCLES),
            .RST_VAL   (1'b1)
        ) u_deb (
            .clk(clk),
            .rst(rst),
            .d_i(induct_n[i]),
            .q_o(induct_filt_s[i])
        );
    end

    sens_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .RST_VAL   (1'b0)
    ) u_deb_prox (
        .clk(clk),
        .rst(rst),
        .d_i(proxim),
        .q_o(proxim_filt_s)
    );

    function automatic lf_class_e classify(input logic [NUM_SENS-1:0] t);
        logic left_s;
        logic right_s;
        left_s  = |t[NUM_SENS-1:CTR+1];
        right_s = |t[CTR-1:0];
        if (t == {NUM_SENS{1'b0}}) begin
            return CL_NONE;
        end else if (t == {NUM_SENS{1'b1}}) begin
            return CL_MARK;
        end else if (left_s && right_s) begin
            return CL_MARK;
        end else if (left_s) begin
            return CL_LEFTSIDE;
        end else if (right_s) begin
            return CL_RIGHTSIDE;
        end else begin
            return CL_CENTRE;
        end
    endfunction

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
        if (v == TMR_SAT) begin
            return v;
        end else begin
            return v + TMR_W'(1);
        end
    endfunction

    assign class_s = classify(~induct_filt_s);

    // A new duty value is picked up only as the counter wraps.
    assign duty_eff_s = (pwm_cnt_q == {PWM_W{1'b0}}) ? duty : duty_q;
    assign pwm_s      = (pwm_cnt_q < duty_eff_s);

    // Free-running PWM counter and latched duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= {PWM_W{1'b0}};
            duty_q    <= {PWM_W{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            duty_q    <= duty_eff_s;
        end
    end

    // FSM state and shared mode timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= TMR_ZERO;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state logic; proxim in FOLLOW outranks the MARK halt.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (!enable) begin
            state_d = ST_IDLE;
            tmr_d   = TMR_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FOLLOW;
                    tmr_d   = TMR_ZERO;
                end
                ST_FOLLOW: begin
                    if (proxim_filt_s) begin
                        state_d = ST_BACKOFF;
                        tmr_d   = TMR_ZERO;
                    end else if (class_s == CL_MARK) begin
                        state_d = ST_HALT;
                        tmr_d   = TMR_ZERO;
                    end else if (class_s == CL_NONE) begin
                        if (tmr_q >= LOST_LAST) begin
                            state_d = ST_LOST;
                            tmr_d   = TMR_ZERO;
                        end else begin
                            tmr_d = tmr_inc(tmr_q);
                        end
                    end else begin
                        tmr_d = TMR_ZERO;
                    end
                end
                ST_BACKOFF: begin
                    if (tmr_q >= BACK_LAST) begin
                        tmr_d = TMR_ZERO;
                        if (proxim_filt_s) begin
                            state_d = ST_BACKOFF;
                        end else begin
                            state_d = ST_FOLLOW;
                        end
                    end else begin
                        tmr_d = tmr_inc(tmr_q);
                    end
                end
                ST_LOST: begin
`ifdef LINE_SEARCH_EN
                    if (class_s != CL_NONE) begin
                        state_d = ST_FOLLOW;
                        tmr_d   = TMR_ZERO;
                    end else if (tmr_q >= SEARCH_LAST) begin
                        state_d = ST_HALT;
                        tmr_d   = TMR_ZERO;
                    end else begin
                        tmr_d = tmr_inc(tmr_q);
                    end
`else
                    state_d = ST_LOST;
                    tmr_d   = TMR_ZERO;
`endif
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                    tmr_d   = TMR_ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = TMR_ZERO;
                end
            endcase
        end
    end

`ifdef LINE_SEARCH_EN
    logic last_right_q;

    // Remembers which side the line was last seen on to pick the spin way.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_right_q <= 1'b0;
        end else if (class_s != CL_NONE) begin
            last_right_q <= (class_s == CL_RIGHTSIDE);
        end else begin
            last_right_q <= last_right_q;
        end
    end
`endif

    // Output decode from current state and tape class.
    always_comb begin
        motor_in_d = motor_in_q;
        motor_en_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                motor_in_d = DIR_STOP;
                motor_en_d = 2'b00;
            end
            ST_FOLLOW: begin
                case (class_s)
                    CL_CENTRE:    motor_in_d = DIR_FWD;
                    CL_LEFTSIDE:  motor_in_d = DIR_LEFT;
                    CL_RIGHTSIDE: motor_in_d = DIR_RIGHT;
                    default:      motor_in_d = motor_in_q;
                endcase
                motor_en_d = en_gate(1'b1, pwm_s);
            end
            ST_BACKOFF: begin
                motor_in_d = DIR_REV;
                motor_en_d = en_gate(1'b1, pwm_s);
            end
            ST_LOST: begin
`ifdef LINE_SEARCH_EN
                if (last_right_q) begin
                    motor_in_d = DIR_RIGHT;
                end else begin
                    motor_in_d = DIR_LEFT;
                end
                motor_en_d = en_gate(1'b1, pwm_s);
`else
                motor_in_d = motor_in_q;
                motor_en_d = 2'b00;
`endif
            end
            ST_HALT: begin
                motor_in_d = motor_in_q;
                motor_en_d = 2'b00;
            end
            default: begin
                motor_in_d = DIR_STOP;
                motor_en_d = 2'b00;
            end
        endcase
    end

    // Registered motor outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            motor_in_q <= DIR_STOP;
            motor_en_q <= 2'b00;
        end else begin
            motor_in_q <= motor_in_d;
            motor_en_q <= motor_en_d;
        end
    end

    assign motorIn = motor_in_q;
    assign motorEn = motor_en_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with short timers (DEB 4, BACKOFF 20,
// LOST 30); expected values are hand-derived cycle counts.
module tb_line_follow_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [2:0] induct_n;
    logic       proxim;
    logic [7:0] duty;
    logic [3:0] motorIn;
    logic [1:0] motorEn;
    logic [2:0] state_o;

    int checks;
    int failures;
    int cnt_on;
    int cnt_bad;

    localparam logic [3:0] D_STOP  = 4'b0000;
    localparam logic [3:0] D_FWD   = 4'b1001;
    localparam logic [3:0] D_LEFT  = 4'b0101;
    localparam logic [3:0] D_RIGHT = 4'b1010;
    localparam logic [3:0] D_REV   = 4'b0110;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FOLLOW  = 3'd1;
    localparam logic [2:0] S_BACKOFF = 3'd2;
    localparam logic [2:0] S_LOST    = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    line_follow_ctrl #(
        .NUM_SENS   (3),
        .DEB_CYCLES (4),
        .PWM_W      (8),
        .BACKOFF_CYC(20),
        .LOST_CYC   (30)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .induct_n(induct_n),
        .proxim  (proxim),
        .duty    (duty),
        .motorIn (motorIn),
        .motorEn (motorEn),
        .state_o (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        induct_n = 3'b111;
        proxim   = 1'b0;
        duty     = 8'd128;
        step(3);
        chk("rst_motorIn", 32'(motorIn), 32'(D_STOP));
        chk("rst_motorEn", 32'(motorEn), 32'(2'b00));
        chk("rst_state", 32'(state_o), 32'(S_IDLE));

        rst      = 1'b0;
        enable   = 1'b1;
        induct_n = 3'b101;
        step(1);
        chk("idle_to_follow", 32'(state_o), 32'(S_FOLLOW));
        step(5);
        chk("fwd_not_before_7", 32'(motorIn), 32'(D_STOP));
        step(1);
        chk("fwd_at_7", 32'(motorIn), 32'(D_FWD));

        cnt_on  = 0;
        cnt_bad = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (motorEn == 2'b11) cnt_on++;
            if (motorEn == 2'b01 || motorEn == 2'b10) cnt_bad++;
        end
        chk("pwm50_on_cycles", 32'(cnt_on), 32'd128);
        chk("pwm_en_split", 32'(cnt_bad), 32'd0);

        induct_n = 3'b011;
        step(7);
        chk("left", 32'(motorIn), 32'(D_LEFT));
        induct_n = 3'b110;
        step(7);
        chk("right", 32'(motorIn), 32'(D_RIGHT));

        induct_n = 3'b011;
        step(2);
        induct_n = 3'b110;
        step(10);
        chk("glitch_ignored", 32'(motorIn), 32'(D_RIGHT));

        induct_n = 3'b101;
        step(7);
        chk("centre_again", 32'(motorIn), 32'(D_FWD));

        proxim  = 1'b1;
        cnt_on  = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (motorIn == D_REV) cnt_on++;
            if (i == 10) proxim = 1'b0;
        end
        chk("rev_cycles", 32'(cnt_on), 32'd20);
        chk("after_backoff_fwd", 32'(motorIn), 32'(D_FWD));
        chk("after_backoff_state", 32'(state_o), 32'(S_FOLLOW));

        proxim = 1'b1;
        step(60);
        chk("held_prox_rev", 32'(motorIn), 32'(D_REV));
        chk("held_prox_state", 32'(state_o), 32'(S_BACKOFF));
        proxim = 1'b0;
        step(60);
        chk("release_prox_fwd", 32'(motorIn), 32'(D_FWD));

        proxim   = 1'b1;
        induct_n = 3'b000;
        step(7);
        chk("prox_beats_mark", 32'(state_o), 32'(S_BACKOFF));
        proxim = 1'b0;
        step(40);
        chk("mark_halt", 32'(state_o), 32'(S_HALT));
        chk("halt_en_off", 32'(motorEn), 32'(2'b00));

        induct_n = 3'b101;
        step(20);
        chk("halt_sticky", 32'(state_o), 32'(S_HALT));
        chk("halt_dir_held", 32'(motorIn), 32'(D_REV));
        enable = 1'b0;
        step(1);
        chk("disable_idle", 32'(state_o), 32'(S_IDLE));
        step(1);
        chk("idle_stop", 32'(motorIn), 32'(D_STOP));
        chk("idle_en_off", 32'(motorEn), 32'(2'b00));
        enable = 1'b1;
        step(1);
        chk("reenable_follow", 32'(state_o), 32'(S_FOLLOW));
        step(1);
        chk("reenable_fwd", 32'(motorIn), 32'(D_FWD));

        induct_n = 3'b111;
        step(35);
        chk("lost_not_yet", 32'(state_o), 32'(S_FOLLOW));
        step(1);
        chk("lost_entered", 32'(state_o), 32'(S_LOST));
        step(1);
`ifdef LINE_SEARCH_EN
        chk("lost_spin_left", 32'(motorIn), 32'(D_LEFT));
        step(58);
        chk("search_not_yet", 32'(state_o), 32'(S_LOST));
        step(1);
        chk("search_halt", 32'(state_o), 32'(S_HALT));
`else
        chk("lost_en_off", 32'(motorEn), 32'(2'b00));
        induct_n = 3'b101;
        step(10);
        chk("lost_sticky", 32'(state_o), 32'(S_LOST));
`endif

        enable   = 1'b0;
        induct_n = 3'b101;
        step(2);
        enable = 1'b1;
        step(10);
        chk("follow_before_rst", 32'(state_o), 32'(S_FOLLOW));
        proxim = 1'b1;
        step(10);
        chk("backoff_before_rst", 32'(state_o), 32'(S_BACKOFF));
        rst = 1'b1;
        step(1);
        chk("midrst_motorIn", 32'(motorIn), 32'(D_STOP));
        chk("midrst_motorEn", 32'(motorEn), 32'(2'b00));
        chk("midrst_state", 32'(state_o), 32'(S_IDLE));

        rst    = 1'b0;
        proxim = 1'b0;
        duty   = 8'd0;
        cnt_on = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (motorEn != 2'b00) cnt_on++;
        end
        chk("duty0_never_on", 32'(cnt_on), 32'd0);
        chk("duty0_dir_fwd", 32'(motorIn), 32'(D_FWD));

        duty = 8'hFF;
        step(256);
        cnt_on = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (motorEn == 2'b11) cnt_on++;
        end
        chk("duty_max_on", 32'(cnt_on), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
